// File: rtl/dmem_responder.sv
// Purpose : word-wide, byte-addressed data memory with zero-clear on reset and misaligned-access rejection.
// Latency : 1 cycle from an accepted aligned read to dout; writes land on the request edge; clear takes DEPTH cycles.
// Backpressure: none; requests arriving before init_done is visible are silently dropped.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   ena            access request for this cycle
//   web            1 = write, 0 = read (qualified by ena)
//   addr           byte address; low OFS bits must be zero
//   din            full-word write data
//   dout           registered read data; holds on writes, idles and rejected accesses
//   init_done      high once every word has been cleared
//   err_misaligned one-cycle pulse after a rejected misaligned access
module dmem_responder #(
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DMEM_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       web,
  input  logic [DMEM_ADDR_WIDTH-1:0] addr,
  input  logic [DMEM_DATA_WIDTH-1:0] din,
  output logic [DMEM_DATA_WIDTH-1:0] dout,
  output logic                       init_done,
  output logic                       err_misaligned
);

  localparam int OFS   = $clog2(DMEM_DATA_WIDTH / 8);
  localparam int IW    = DMEM_ADDR_WIDTH - OFS;
  localparam int DEPTH = 2 ** IW;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                     state;
  logic [IW-1:0]              cnt;
  logic [DMEM_DATA_WIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]              idx;
  logic                       misal;
  logic                       svc;
  logic                       mem_we;
  logic [IW-1:0]              mem_widx;
  logic [DMEM_DATA_WIDTH-1:0] mem_wdat;

  assign idx   = addr[DMEM_ADDR_WIDTH-1:OFS];
  assign misal = (addr[OFS-1:0] != '0);
  // Service only once init_done is already registered high, so a request
  // on the very edge init_done rises is dropped.
  assign svc   = (state == READY) && init_done && ena;

  // Single write port shared by the clear sequencer and aligned writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = idx;
    mem_wdat = din;
    if (state == INIT) begin
      mem_we   = 1'b1;
      mem_widx = cnt;
      mem_wdat = '0;
    end else if (svc && web && !misal) begin
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= INIT;
      cnt            <= '0;
      dout           <= '0;
      init_done      <= 1'b0;
      err_misaligned <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          err_misaligned <= 1'b0;
          // Counter parks at LAST; it is not touched again until reset.
          if (cnt == LAST) begin
            state <= READY;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        READY: begin
          init_done      <= 1'b1;
          err_misaligned <= svc && misal;
          if (svc && !web && !misal) begin
            dout <= mem[idx];
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
